// File: rtl/pipeline_hazard_controller_if.sv
// Hazard-control bundle between the pipeline datapath/data memory and the controller.
// master = controller side, slave = datapath / memory side.
interface pipeline_hazard_controller_if #(
  parameter int CNT_W = 32
);
  logic             MemRead_EX;
  logic [4:0]       rd_EX;
  logic [4:0]       rs1_ID;
  logic [4:0]       rs2_ID;
  logic             rs2_used_ID;
  logic             branch_taken_MEM;
  logic             mem_access_MEM;
  logic             dmem_ready;
  logic             dmem_req;
  logic             pc_write;
  logic             pc_src;
  logic             if_id_write;
  logic             if_id_flush;
  logic             id_ex_bubble;
  logic             ex_mem_write;
  logic             ex_mem_flush;
  logic             mem_wb_bubble;
  logic             fault;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_events;

  modport master (
    input  MemRead_EX, rd_EX, rs1_ID, rs2_ID, rs2_used_ID,
           branch_taken_MEM, mem_access_MEM, dmem_ready,
    output dmem_req, pc_write, pc_src, if_id_write, if_id_flush,
           id_ex_bubble, ex_mem_write, ex_mem_flush, mem_wb_bubble,
           fault, stall_cycles, flush_events
  );

  modport slave (
    output MemRead_EX, rd_EX, rs1_ID, rs2_ID, rs2_used_ID,
           branch_taken_MEM, mem_access_MEM, dmem_ready,
    input  dmem_req, pc_write, pc_src, if_id_write, if_id_flush,
           id_ex_bubble, ex_mem_write, ex_mem_flush, mem_wb_bubble,
           fault, stall_cycles, flush_events
  );
endinterface

// File: rtl/pipeline_hazard_controller.sv
// 5-stage pipeline hazard controller: load-use stall, MEM-stage branch flush,
// data-memory wait freeze with timeout fault, saturating performance counters.
//   state    | meaning
//   ST_RUN   | normal flow; load-use / branch handling active
//   ST_WAIT  | data memory access outstanding, pipeline frozen
//   ST_FAULT | access timed out; pipeline frozen until reset
module pipeline_hazard_controller #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic                           clk,
  input  logic                           reset,
  pipeline_hazard_controller_if.master   bus
);
  localparam int WCNT_W = $clog2(MEM_TIMEOUT);

  typedef enum logic [1:0] {ST_RUN, ST_WAIT, ST_FAULT} state_t;

  state_t           state, state_nxt;
  logic [WCNT_W-1:0] wcnt, wcnt_nxt;
  logic [CNT_W-1:0] stall_cycles, flush_events;
  logic             fault_q;
  logic             stall_inc, flush_inc, fault_set;
  logic             load_use;

  logic dmem_req_c, pc_write_c, pc_src_c, if_id_write_c, if_id_flush_c;
  logic id_ex_bubble_c, ex_mem_write_c, ex_mem_flush_c, mem_wb_bubble_c;

  assign load_use = bus.MemRead_EX && (bus.rd_EX != 5'd0) &&
                    ((bus.rd_EX == bus.rs1_ID) ||
                     (bus.rs2_used_ID && (bus.rd_EX == bus.rs2_ID)));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_RUN;
      wcnt         <= '0;
      stall_cycles <= '0;
      flush_events <= '0;
      fault_q      <= 1'b0;
    end else begin
      state <= state_nxt;
      wcnt  <= wcnt_nxt;
      if (stall_inc && (stall_cycles != '1))
        stall_cycles <= stall_cycles + CNT_W'(1);
      if (flush_inc && (flush_events != '1))
        flush_events <= flush_events + CNT_W'(1);
      if (fault_set)
        fault_q <= 1'b1;
    end
  end

  always_comb begin
    state_nxt       = state;
    wcnt_nxt        = wcnt;
    stall_inc       = 1'b0;
    flush_inc       = 1'b0;
    fault_set       = 1'b0;
    dmem_req_c      = 1'b0;
    pc_write_c      = 1'b1;
    pc_src_c        = 1'b0;
    if_id_write_c   = 1'b1;
    if_id_flush_c   = 1'b0;
    id_ex_bubble_c  = 1'b0;
    ex_mem_write_c  = 1'b1;
    ex_mem_flush_c  = 1'b0;
    mem_wb_bubble_c = 1'b0;

    case (state)
      ST_RUN, ST_WAIT: begin
        dmem_req_c = bus.mem_access_MEM;
        if ((state == ST_WAIT || bus.mem_access_MEM) && !bus.dmem_ready) begin
          pc_write_c      = 1'b0;
          if_id_write_c   = 1'b0;
          ex_mem_write_c  = 1'b0;
          mem_wb_bubble_c = 1'b1;
          stall_inc       = 1'b1;
          if (state == ST_RUN) begin
            state_nxt = ST_WAIT;
            wcnt_nxt  = WCNT_W'(1);
          end else if (wcnt == WCNT_W'(MEM_TIMEOUT - 1)) begin
            state_nxt = ST_FAULT;
            fault_set = 1'b1;
          end else begin
            wcnt_nxt = wcnt + WCNT_W'(1);
          end
        end else begin
          state_nxt = ST_RUN;
          // Branch resolution squashes the younger load, so load-use is moot.
          if (bus.branch_taken_MEM) begin
            pc_src_c       = 1'b1;
            if_id_flush_c  = 1'b1;
            id_ex_bubble_c = 1'b1;
            ex_mem_flush_c = 1'b1;
            flush_inc      = 1'b1;
          end else if (load_use) begin
            pc_write_c     = 1'b0;
            if_id_write_c  = 1'b0;
            id_ex_bubble_c = 1'b1;
            stall_inc      = 1'b1;
          end
        end
      end
      default: begin
        pc_write_c      = 1'b0;
        if_id_write_c   = 1'b0;
        ex_mem_write_c  = 1'b0;
        mem_wb_bubble_c = 1'b1;
      end
    endcase
  end

  assign bus.dmem_req      = dmem_req_c;
  assign bus.pc_write      = pc_write_c;
  assign bus.pc_src        = pc_src_c;
  assign bus.if_id_write   = if_id_write_c;
  assign bus.if_id_flush   = if_id_flush_c;
  assign bus.id_ex_bubble  = id_ex_bubble_c;
  assign bus.ex_mem_write  = ex_mem_write_c;
  assign bus.ex_mem_flush  = ex_mem_flush_c;
  assign bus.mem_wb_bubble = mem_wb_bubble_c;
  assign bus.fault         = fault_q;
  assign bus.stall_cycles  = stall_cycles;
  assign bus.flush_events  = flush_events;
endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed-vector bench for pipeline_hazard_controller (MEM_TIMEOUT=4, CNT_W=3).
module tb_pipeline_hazard_controller;
  logic clk;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;

  pipeline_hazard_controller_if #(.CNT_W(3)) bus ();

  pipeline_hazard_controller #(.MEM_TIMEOUT(4), .CNT_W(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {dmem_req, pc_write, pc_src, if_id_write, if_id_flush,
  //  id_ex_bubble, ex_mem_write, ex_mem_flush, mem_wb_bubble, fault}
  localparam logic [9:0] V_DEF  = 10'b0101001000;
  localparam logic [9:0] V_LU   = 10'b0000011000;
  localparam logic [9:0] V_BR   = 10'b0111111100;
  localparam logic [9:0] V_FRZ  = 10'b1000000010;
  localparam logic [9:0] V_FRZ0 = 10'b0000000010;
  localparam logic [9:0] V_ZW   = 10'b1101001000;
  localparam logic [9:0] V_FLT  = 10'b0000000011;

  logic [9:0] ctrl;
  assign ctrl = {bus.dmem_req, bus.pc_write, bus.pc_src, bus.if_id_write,
                 bus.if_id_flush, bus.id_ex_bubble, bus.ex_mem_write,
                 bus.ex_mem_flush, bus.mem_wb_bubble, bus.fault};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic idle();
    bus.MemRead_EX       = 1'b0;
    bus.rd_EX            = 5'd0;
    bus.rs1_ID           = 5'd0;
    bus.rs2_ID           = 5'd0;
    bus.rs2_used_ID      = 1'b0;
    bus.branch_taken_MEM = 1'b0;
    bus.mem_access_MEM   = 1'b0;
    bus.dmem_ready       = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
    #1;
  endtask

  task automatic set_load(input logic [4:0] rd, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic used2);
    bus.MemRead_EX  = 1'b1;
    bus.rd_EX       = rd;
    bus.rs1_ID      = rs1;
    bus.rs2_ID      = rs2;
    bus.rs2_used_ID = used2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    idle();
    #3;
    check("in_reset_ctrl", 32'(ctrl), 32'(V_DEF));
    tick();
    tick();
    reset = 1'b0;
    #1;
    check("post_reset_ctrl", 32'(ctrl), 32'(V_DEF));
    check("post_reset_stall", 32'(bus.stall_cycles), 32'd0);
    check("post_reset_flush", 32'(bus.flush_events), 32'd0);

    // load-use via rs1
    set_load(5'd5, 5'd5, 5'd0, 1'b0);
    #1;
    check("lu_rs1_ctrl", 32'(ctrl), 32'(V_LU));
    tick();
    idle();
    #1;
    check("lu_rs1_stall", 32'(bus.stall_cycles), 32'd1);
    check("lu_after_ctrl", 32'(ctrl), 32'(V_DEF));

    // rd = x0 never hazards
    set_load(5'd0, 5'd0, 5'd0, 1'b1);
    #1;
    check("lu_x0_ctrl", 32'(ctrl), 32'(V_DEF));
    tick();
    check("lu_x0_stall", 32'(bus.stall_cycles), 32'd1);

    // rs2 match ignored when rs2 unused, honoured when used
    set_load(5'd5, 5'd3, 5'd5, 1'b0);
    #1;
    check("lu_rs2_unused", 32'(ctrl), 32'(V_DEF));
    bus.rs2_used_ID = 1'b1;
    #1;
    check("lu_rs2_used", 32'(ctrl), 32'(V_LU));
    tick();
    idle();
    #1;
    check("lu_rs2_stall", 32'(bus.stall_cycles), 32'd2);

    // branch with simultaneous load-use: branch wins
    set_load(5'd5, 5'd5, 5'd0, 1'b0);
    bus.branch_taken_MEM = 1'b1;
    #1;
    check("br_ctrl", 32'(ctrl), 32'(V_BR));
    tick();
    idle();
    #1;
    check("br_flush_cnt", 32'(bus.flush_events), 32'd1);
    check("br_stall_same", 32'(bus.stall_cycles), 32'd2);

    // zero-wait access
    bus.mem_access_MEM = 1'b1;
    bus.dmem_ready     = 1'b1;
    #1;
    check("zw_ctrl", 32'(ctrl), 32'(V_ZW));
    tick();
    check("zw_stall", 32'(bus.stall_cycles), 32'd2);

    // 3-cycle memory wait, branch ignored while frozen
    idle();
    pulse_reset();
    bus.mem_access_MEM = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.branch_taken_MEM = (i == 1);
      #1;
      check($sformatf("mw_frz%0d", i), 32'(ctrl), 32'(V_FRZ));
      tick();
    end
    bus.branch_taken_MEM = 1'b0;
    bus.dmem_ready       = 1'b1;
    #1;
    check("mw_ready_ctrl", 32'(ctrl), 32'(V_ZW));
    tick();
    idle();
    #1;
    check("mw_stall", 32'(bus.stall_cycles), 32'd3);
    check("mw_flush", 32'(bus.flush_events), 32'd0);
    check("mw_back_run", 32'(ctrl), 32'(V_DEF));

    // timeout after 4 wait edges
    pulse_reset();
    bus.mem_access_MEM = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("to_frz%0d", i), 32'(ctrl), 32'(V_FRZ));
      tick();
    end
    check("to_fault_ctrl", 32'(ctrl), 32'(V_FLT));
    check("to_stall", 32'(bus.stall_cycles), 32'd4);
    set_load(5'd5, 5'd5, 5'd0, 1'b0);
    bus.branch_taken_MEM = 1'b1;
    bus.dmem_ready       = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      check($sformatf("to_hold%0d", i), 32'(ctrl), 32'(V_FLT));
    end
    check("to_stall_frozen", 32'(bus.stall_cycles), 32'd4);
    check("to_flush_frozen", 32'(bus.flush_events), 32'd0);
    idle();

    // asynchronous reset mid-WAIT
    pulse_reset();
    bus.mem_access_MEM = 1'b1;
    tick();
    tick();
    check("rw_stall", 32'(bus.stall_cycles), 32'd2);
    bus.mem_access_MEM = 1'b0;
    #1;
    check("rw_wait_ctrl", 32'(ctrl), 32'(V_FRZ0));
    #1;
    reset = 1'b1;
    #1;
    check("rw_reset_ctrl", 32'(ctrl), 32'(V_DEF));
    check("rw_reset_stall", 32'(bus.stall_cycles), 32'd0);
    reset = 1'b0;
    tick();
    check("rw_after_ctrl", 32'(ctrl), 32'(V_DEF));

    // saturation at 7
    set_load(5'd7, 5'd7, 5'd0, 1'b0);
    for (int i = 1; i <= 9; i++) begin
      tick();
      check($sformatf("sat%0d", i), 32'(bus.stall_cycles), (i > 7) ? 32'd7 : 32'(i));
    end
    idle();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
